neuron_seq: RTL
===============

// Module: neuron_seq
// PURPOSE
//  Sequencer and accumulator that drives the combinational MAC (a*b+c, Q<int_part>.<fract_part>).
//  Accepts N_INPUTS (x, w) pairs over a valid/ready stream, starting from a bias value.
//  Presents each pair plus the running accumulator to the MAC and registers the MAC result as the new accumulator.
//  Outputs one neuron value per start, through an output valid/ready handshake.
// PARAMETERS
//  int_part    3  integer bits of the two's-complement fixed-point format, sign bit included
//  fract_part  2  fractional bits; W = int_part+fract_part
//  N_INPUTS    4  pairs accumulated per neuron, >=1; counter width = $clog2(N_INPUTS+1)
// PORTS
//  clk        in   1  clock, all state on rising edge
//  rst        in   1  asynchronous active-high reset
//  start      in   1  begin a neuron; sampled only in IDLE
//  bias       in   W  signed initial accumulator value, sampled with start
//  in_valid   in   1  x_in/w_in valid
//  in_ready   out  1  block accepts a pair this cycle
//  x_in       in   W  signed activation
//  w_in       in   W  signed weight
//  mac_a      out  W  to MAC a; = x_in (combinational)
//  mac_b      out  W  to MAC b; = w_in (combinational)
//  mac_c      out  W  to MAC c; = acc register
//  mac_res    in   W  from MAC mac output
//  out_valid  out  1  y_out holds a finished neuron value
//  out_ready  in   1  consumer accepts y_out
//  y_out      out  W  signed neuron output, registered
//  busy       out  1  high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE, acc=0, cnt=0, y_out=0, in_ready=0, out_valid=0, busy=0.
//  States:
//  - IDLE: on start, acc<=bias, cnt<=0, go to ACC.
//  - ACC: in_ready=1.
//    - Pair accepted when in_valid&&in_ready: acc<=mac_res, cnt<=cnt+1.
//    - Accept with cnt==N_INPUTS-1: y_out<=act(mac_res), go to OUT.
//    - in_valid low: stall; acc and cnt held.
//  - OUT: out_valid=1, in_ready=0, y_out stable. On out_ready, go to IDLE (out_valid low next cycle).
//  Latency: y_out/out_valid are asserted in the cycle after the last pair is accepted.
//    Minimum start-to-start period is N_INPUTS+2 cycles.
//  Handshakes:
//  - One pair per cycle max.
//  - in_ready is a function of state only, never of in_valid.
//  - out_valid is not dropped until out_ready.
//  Arithmetic:
//  - Full product width and the rounding/truncation policy belong to the MAC. This block adds no saturation.
//  - An overflowing sum wraps exactly as the MAC returns it.
//  Boundaries:
//  - start outside IDLE is ignored.
//  - start in the same cycle as the OUT->IDLE return is ignored; start is sampled one cycle later.
//  - in_valid outside ACC is ignored; no pair is consumed.
//  - N_INPUTS=1: ACC lasts exactly one accepted pair.
//  - rst at any time, including mid-ACC or OUT, aborts immediately to the reset values. The partial sum is discarded.
// CONFIGURATION
//  NEURON_RELU_EN defined: act(v) = (v[W-1] ? 0 : v), so y_out is never negative.
//  NEURON_RELU_EN undefined: act(v) = v, identity; y_out may be negative.
// TESTING  (W=5, fract_part=2: 1.0=5'b00100, 0.5=5'b00010, -1.0=5'b11100)
//  1. start, bias=0, 4 pairs x=1.0, w=0.5, in_valid held high
//     -> in_ready high for 4 cycles; out_valid on cycle 5; y_out=5'b01000 (2.0).
//  2. Same pairs with in_valid low for 3 cycles between pairs 2 and 3
//     -> acc/cnt held during the gaps; y_out=2.0; out_valid 3 cycles later than scenario 1.
//  3. bias=-1.0, 4 pairs x=0, w=0
//     -> y_out=5'b00000 with NEURON_RELU_EN; y_out=5'b11100 without it.
//  4. out_ready low for 5 cycles after out_valid, with start pulsed meanwhile
//     -> y_out and out_valid stable; start ignored; IDLE one cycle after out_ready.
//  5. rst pulsed after 2 accepted pairs
//     -> all outputs at reset values while rst is high; next start with bias=0 and 4x(1.0,0.5) gives exactly 2.0.
//  6. Sum overflow: bias=3.75 (01111), pair x=1.0, w=0.5
//     -> acc equals the MAC's returned value bit-exactly; no saturation.

Source files
------------

// File: rtl/neuron_seq_if.sv
// neuron_seq_if: bundles every non-clock/reset signal of neuron_seq.
//
// Handshake rules for both streams (in_* and out_*): a transfer happens on
// a rising clock edge where valid and ready are both high. in_ready depends
// only on the sequencer state, never on in_valid. Once out_valid is raised,
// it and y_out stay unchanged until out_ready is seen.
//
// Signals
//   start, bias           neuron launch and initial accumulator value
//   in_valid/in_ready     (x_in, w_in) pair stream
//   mac_a/b/c, mac_res    connection to the external combinational MAC
//   out_valid/out_ready   neuron result stream carrying y_out
//   busy                  high whenever the sequencer is not idle
//   state_dbg             sequencer state: 0 idle, 1 accumulate, 2 output
//
// Modports
//   slave  : the neuron_seq side
//   master : the environment side (driver, MAC, consumer)
interface neuron_seq_if #(
    parameter int W = 5
);
    logic         start;
    logic [W-1:0] bias;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x_in;
    logic [W-1:0] w_in;
    logic [W-1:0] mac_a;
    logic [W-1:0] mac_b;
    logic [W-1:0] mac_c;
    logic [W-1:0] mac_res;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y_out;
    logic         busy;
    logic [1:0]   state_dbg;

    modport slave (
        input  start, bias, in_valid, x_in, w_in, mac_res, out_ready,
        output in_ready, mac_a, mac_b, mac_c, out_valid, y_out, busy, state_dbg
    );

    modport master (
        output start, bias, in_valid, x_in, w_in, mac_res, out_ready,
        input  in_ready, mac_a, mac_b, mac_c, out_valid, y_out, busy, state_dbg
    );
endinterface

// File: rtl/neuron_seq.sv
// neuron_seq: sequencer and accumulator around an external combinational
// MAC (a*b+c, signed fixed point Q<int_part>.<fract_part>).
//
// A start pulse in IDLE loads bias into the accumulator. N_INPUTS (x, w)
// pairs are then accepted. For each pair the MAC result becomes the new
// accumulator. After the last pair, the activated result is held on y_out
// until the consumer takes it.
//
// Ports
//   clk   rising-edge clock
//   rst   asynchronous active-high reset; it aborts any neuron in flight
//   bus   neuron_seq_if.slave: start/bias, in_* pair stream, mac_* MAC
//         connection, out_* result stream, busy, state_dbg
//
// Configuration macro NEURON_RELU_EN:
//   defined   -> act(v) = v < 0 ? 0 : v
//   undefined -> act(v) = v
module neuron_seq #(
    parameter int int_part   = 3,
    parameter int fract_part = 2,
    parameter int N_INPUTS   = 4
) (
    input  logic         clk,
    input  logic         rst,
    neuron_seq_if.slave  bus
);
    localparam int W  = int_part + fract_part;
    localparam int CW = $clog2(N_INPUTS + 1);
    localparam logic [CW-1:0] LAST = CW'(N_INPUTS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  y_q, y_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;
    logic          accept;

    function automatic logic [W-1:0] act(input logic [W-1:0] v);
`ifdef NEURON_RELU_EN
        act = v[W-1] ? '0 : v;
`else
        act = v;
`endif
    endfunction

    // in_ready is registered high only in ACC, so the accept term reduces
    // to the state plus in_valid.
    assign accept = (state_q == S_ACC) && bus.in_valid;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        y_d         = y_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    acc_d      = bus.bias;
                    cnt_d      = '0;
                    state_d    = S_ACC;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            S_ACC: begin
                if (accept) begin
                    // The MAC result is taken as-is. Any wrap in the MAC
                    // sum carries straight into the accumulator.
                    acc_d = bus.mac_res;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        y_d         = act(bus.mac_res);
                        state_d     = S_OUT;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_OUT: begin
                // A start arriving in this cycle is ignored because the
                // state is still OUT. It is seen again from IDLE.
                if (bus.out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            y_q         <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            y_q         <= y_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.mac_a     = bus.x_in;
    assign bus.mac_b     = bus.w_in;
    assign bus.mac_c     = acc_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.y_out     = y_q;
    assign bus.busy      = busy_q;
    assign bus.state_dbg = state_q;
endmodule
